// File: rtl/pin_event_buffer_pkg.sv
// Shared constants and event layout for the probe readout path.
// The sender and the analyser use the same definitions.
package pin_event_buffer_pkg;

  localparam int PIN_W   = 8;
  localparam int TIME_W  = 32;
  localparam int EVENT_W = TIME_W + PIN_W;

  localparam int EV_TIME_MSB = EVENT_W - 1;
  localparam int EV_TIME_LSB = PIN_W;
  localparam int EV_PINS_MSB = PIN_W - 1;
  localparam int EV_PINS_LSB = 0;

  function automatic logic [EVENT_W-1:0] pack_event(input logic [TIME_W-1:0] t,
                                                    input logic [PIN_W-1:0]  p);
    logic [EVENT_W-1:0] ev;
    ev = '0;
    ev[EV_TIME_MSB:EV_TIME_LSB] = t;
    ev[EV_PINS_MSB:EV_PINS_LSB] = p;
    return ev;
  endfunction

endpackage

// File: rtl/pin_event_buffer_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a read frees the slot a
// same-cycle write may use, so a full FIFO accepts push+pop together.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                do_wr, do_rd;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign do_rd   = rd_en_i && !empty_o;
  assign do_wr   = wr_en_i && (!full_o || do_rd);
  assign level_o = wr_ptr_q - rd_ptr_q;

  // Head reads as zero while empty so the output is clean out of reset.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/pin_event_buffer.sv
// Synchronises the probe pins, timestamps every change of the pin vector
// and queues {time, pins} events for the SPI sender to drain.
module pin_event_buffer
  import pin_event_buffer_pkg::*;
#(
  parameter int                DEPTH_LOG2 = 4,
  parameter logic [TIME_W-1:0] TIME_INIT  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PIN_W-1:0]     pin_values_i,
  output logic [EVENT_W-1:0]   event_data_o,
  output logic                 event_valid_o,
  input  logic                 event_pop_i,
  output logic                 overflow_o,
  output logic [DEPTH_LOG2:0]  fill_level_o
);

  localparam logic [TIME_W-1:0] TIME_ONE = 1;

  logic [PIN_W-1:0]   sync1_q, sync2_q, prev_q;
  logic [TIME_W-1:0]  time_q, time_d;
  logic               wr_en_q, wr_en_d;
  logic [EVENT_W-1:0] wr_data_q, wr_data_d;
  logic               overflow_q, overflow_d;
  logic               fifo_empty, fifo_full;

  // A change is stamped with the counter value of the cycle it is seen in;
  // the write itself is registered one cycle later.
  always_comb begin
    time_d     = time_q + TIME_ONE;
    wr_en_d    = (sync2_q != prev_q);
    wr_data_d  = pack_event(time_q, sync2_q);
    overflow_d = overflow_q |
                 (wr_en_q & fifo_full & ~(event_pop_i & ~fifo_empty));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      time_q     <= TIME_INIT;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= pin_values_i;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      time_q     <= time_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH      (EVENT_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en_q),
    .wr_data_i (wr_data_q),
    .rd_en_i   (event_pop_i),
    .rd_data_o (event_data_o),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .level_o   (fill_level_o)
  );

  assign event_valid_o = ~fifo_empty;
  assign overflow_o    = overflow_q;

endmodule
